// File: rtl/kamikaze_pkg.sv
// Shared definitions for the kamikaze fetch path.
// Holds the responder state encoding and common constants.
package kamikaze_pkg;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_e;

    localparam int unsigned IMEM_TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] IMEM_NOP = 32'h0000_0000;

endpackage

// File: rtl/kamikaze_bus_timeout.sv
// Saturating wait-cycle counter for the instruction bus.
// expired is high on the LIMIT-th enabled cycle after clear.
module kamikaze_bus_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);
    localparam logic [W-1:0] TOP = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && count != TOP) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/kamikaze_imem_responder.sv
// Memory-side responder for the fetch FIFO: Wishbone-classic word reads
// with a one-word last-fetch buffer that serves address replays locally.
module kamikaze_imem_responder
    import kamikaze_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = IMEM_TIMEOUT_DEFAULT,
    parameter logic [29:0] RESET_ADDR = 30'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_mem_i,
    input  logic        branch_i,
    output logic [31:0] ir_o,
    output logic        memory_ready_o,
    output logic        fetch_err_o,
    output logic [29:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    imem_state_e state_q, state_d;

    logic [29:0] tag_q, tag_d;
    logic [31:0] word_q, word_d;
    logic        valid_q, valid_d;
    logic [29:0] req_tag_q, req_tag_d;
    logic [29:0] serve_tag_q, serve_tag_d;
    logic [31:0] ir_q, ir_d;
    logic        err_q, err_d;
    logic        cyc_q, cyc_d;
    logic [29:0] adr_q, adr_d;

    logic [29:0] pc_tag;
    logic        hit;
    logic        tmo_clear;
    logic        tmo_expired;
    logic        unused_pc_lsb;

    assign pc_tag = pc_mem_i[31:2];
    assign hit = valid_q && (pc_tag == tag_q);
    assign unused_pc_lsb = ^pc_mem_i[1:0];

    kamikaze_bus_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk_i),
        .rst    (rst_i),
        .clear  (tmo_clear),
        .enable (state_q == IMEM_WAIT),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IMEM_IDLE;
            tag_q       <= RESET_ADDR;
            word_q      <= IMEM_NOP;
            valid_q     <= 1'b0;
            req_tag_q   <= '0;
            serve_tag_q <= '0;
            ir_q        <= '0;
            err_q       <= 1'b0;
            cyc_q       <= 1'b0;
            adr_q       <= '0;
        end else begin
            state_q     <= state_d;
            tag_q       <= tag_d;
            word_q      <= word_d;
            valid_q     <= valid_d;
            req_tag_q   <= req_tag_d;
            serve_tag_q <= serve_tag_d;
            ir_q        <= ir_d;
            err_q       <= err_d;
            cyc_q       <= cyc_d;
            adr_q       <= adr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tag_d       = tag_q;
        word_d      = word_q;
        valid_d     = valid_q;
        req_tag_d   = req_tag_q;
        serve_tag_d = serve_tag_q;
        ir_d        = ir_q;
        err_d       = err_q;
        cyc_d       = cyc_q;
        adr_d       = adr_q;
        tmo_clear   = 1'b0;

        unique case (state_q)
            IMEM_IDLE: begin
                if (!branch_i) begin
                    serve_tag_d = pc_tag;
                    if (hit) begin
                        ir_d    = word_q;
                        err_d   = 1'b0;
                        state_d = IMEM_RESP;
                    end else begin
                        req_tag_d = pc_tag;
                        adr_d     = pc_tag;
                        cyc_d     = 1'b1;
                        tmo_clear = 1'b1;
                        state_d   = IMEM_WAIT;
                    end
                end
            end
            IMEM_WAIT: begin
                if (branch_i) begin
                    // Data acked under a flush is still valid for its tag.
                    cyc_d   = 1'b0;
                    state_d = IMEM_IDLE;
                    if (wb_ack_i && !wb_err_i) begin
                        word_d  = wb_dat_i;
                        tag_d   = req_tag_q;
                        valid_d = 1'b1;
                    end
                end else if (wb_err_i) begin
                    cyc_d   = 1'b0;
                    valid_d = 1'b0;
                    ir_d    = IMEM_NOP;
                    err_d   = 1'b1;
                    state_d = IMEM_RESP;
                end else if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    word_d  = wb_dat_i;
                    tag_d   = req_tag_q;
                    valid_d = 1'b1;
                    ir_d    = wb_dat_i;
                    err_d   = 1'b0;
                    state_d = IMEM_RESP;
                end else if (tmo_expired) begin
                    cyc_d   = 1'b0;
                    valid_d = 1'b0;
                    ir_d    = IMEM_NOP;
                    err_d   = 1'b1;
                    state_d = IMEM_RESP;
                end
            end
            IMEM_RESP: begin
                state_d = IMEM_IDLE;
            end
            default: begin
                state_d = IMEM_IDLE;
            end
        endcase
    end

    // The pulse is dropped if the FIFO moved on or flushed meanwhile.
    assign memory_ready_o = (state_q == IMEM_RESP)
                         && (pc_tag == serve_tag_q)
                         && !branch_i;
    assign fetch_err_o = memory_ready_o && err_q;
    assign ir_o        = ir_q;
    assign wb_adr_o    = adr_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = cyc_q;

endmodule

// File: tb/tb_kamikaze_imem_responder.sv
// Scoreboard bench for kamikaze_imem_responder against a configurable
// Wishbone slave (wait states, error, silent).
module tb_kamikaze_imem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_mem;
    logic        branch;
    logic [31:0] ir;
    logic        memory_ready;
    logic        fetch_err;
    logic [29:0] wb_adr;
    logic        wb_cyc;
    logic        wb_stb;
    logic [31:0] wb_dat;
    logic        wb_ack;
    logic        wb_err;

    typedef struct packed {
        logic [31:0] ir;
        logic        err;
    } resp_t;

    resp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int waits = 0;
    bit sl_err = 1'b0;
    bit sl_silent = 1'b0;
    int wcnt = 0;
    int reads = 0;
    int cyc_cycles = 0;
    logic cyc_prev = 1'b0;
    logic [29:0] last_adr = '0;

    always #5 clk = ~clk;

    kamikaze_imem_responder #(
        .TIMEOUT_CYCLES(8),
        .RESET_ADDR(30'h0)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .pc_mem_i      (pc_mem),
        .branch_i      (branch),
        .ir_o          (ir),
        .memory_ready_o(memory_ready),
        .fetch_err_o   (fetch_err),
        .wb_adr_o      (wb_adr),
        .wb_cyc_o      (wb_cyc),
        .wb_stb_o      (wb_stb),
        .wb_dat_i      (wb_dat),
        .wb_ack_i      (wb_ack),
        .wb_err_i      (wb_err)
    );

    function automatic logic [31:0] mem_word(logic [29:0] a);
        return {a, 2'b01} ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    assign wb_dat = wb_cyc ? mem_word(wb_adr) : 32'hDEAD_BEEF;
    assign wb_ack = wb_cyc && wb_stb && !sl_silent && !sl_err && wcnt == waits;
    assign wb_err = wb_cyc && wb_stb && !sl_silent && sl_err && wcnt == waits;

    always @(posedge clk) wcnt <= wb_cyc ? wcnt + 1 : 0;

    always @(negedge clk) begin
        resp_t r;
        if (wb_cyc && !cyc_prev) reads++;
        if (wb_cyc) begin
            cyc_cycles++;
            last_adr = wb_adr;
        end
        cyc_prev = wb_cyc;
        if (memory_ready) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", 32'(memory_ready), 32'd0);
            end else begin
                r = sb.pop_front();
                chk("sb_ir", ir, r.ir);
                chk("sb_err", 32'(fetch_err), 32'(r.err));
            end
        end
    end

    task automatic fetch(string tag, logic [31:0] addr, logic [31:0] exp_ir,
                         logic exp_err, int exp_lat, int exp_reads);
        int lat = -1;
        int r0 = reads;
        sb.push_back(resp_t'{ir: exp_ir, err: exp_err});
        pc_mem = addr;
        branch = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            if (memory_ready) begin
                lat = i;
                break;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        @(posedge clk);
        #1;
        branch = 1'b1;
        chk({tag, "_reads"}, reads - r0, exp_reads);
    endtask

    initial begin
        int r0;
        int c0;
        rst = 1'b1;
        pc_mem = '0;
        branch = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_ready", 32'(memory_ready), 32'd0);
        chk("rst_err", 32'(fetch_err), 32'd0);
        chk("rst_ir", ir, 32'd0);
        chk("rst_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_adr", 32'(wb_adr), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        fetch("zw100", 32'h100, mem_word(30'h40), 1'b0, 2, 1);
        chk("zw100_adr", 32'(last_adr), 32'h40);

        fetch("rd104", 32'h104, mem_word(30'h41), 1'b0, 2, 1);
        fetch("rp104", 32'h104, mem_word(30'h41), 1'b0, 1, 0);

        waits = 3;
        c0 = cyc_cycles;
        fetch("w3_100", 32'h100, mem_word(30'h40), 1'b0, 5, 1);
        chk("w3_cyc", cyc_cycles - c0, 4);
        chk("w3_adr", 32'(last_adr), 32'h40);
        waits = 0;

        r0 = reads;
        pc_mem = 32'h200;
        branch = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("br_ack_seen", 32'(wb_ack), 32'd1);
        #1;
        branch = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("br_reads", reads - r0, 1);
        fetch("br_hit200", 32'h200, mem_word(30'h80), 1'b0, 1, 0);

        sl_err = 1'b1;
        fetch("err300", 32'h300, 32'h0, 1'b1, 2, 1);
        sl_err = 1'b0;
        fetch("re300", 32'h300, mem_word(30'hC0), 1'b0, 2, 1);

        pc_mem = 32'h500;
        branch = 1'b0;
        @(posedge clk);
        #1;
        pc_mem = 32'h504;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mv_ready", 32'(memory_ready), 32'd0);
        #1;
        branch = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fetch("mv500", 32'h500, mem_word(30'h140), 1'b0, 1, 0);

        fetch("wrapF", 32'hFFFF_FFFC, mem_word(30'h3FFF_FFFF), 1'b0, 2, 1);
        fetch("wrap0", 32'h0, mem_word(30'h0), 1'b0, 2, 1);
        fetch("lsb2", 32'h2, mem_word(30'h0), 1'b0, 1, 0);

        sl_silent = 1'b1;
        c0 = cyc_cycles;
        fetch("tmo600", 32'h600, 32'h0, 1'b1, 9, 1);
        chk("tmo_cyc", cyc_cycles - c0, 8);

        pc_mem = 32'h700;
        branch = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_cyc", 32'(wb_cyc), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_cyc", 32'(wb_cyc), 32'd0);
        chk("rst_mid_stb", 32'(wb_stb), 32'd0);
        @(posedge clk);
        #1;
        branch = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sl_silent = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        fetch("post_rst", 32'h700, mem_word(30'h1C0), 1'b0, 2, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_left", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end expected end before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
